// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: arbitrates two command requesters onto four registered ALU units and returns one result per command.
// Latency: accept at edge 0, unit enable in cycle 1, result capture at edge 2, RSP_VALID from cycle 3.
// Backpressure: RSP_READY low holds the response indefinitely; no new command is accepted until it is consumed.
//
// Ports:
//   CLK, RST                      - clock and synchronous active-high reset
//   REQx_VALID/READY/A/B/OP       - command channels of requesters 0 and 1 (OP[3:2] unit, OP[1:0] function)
//   A, B, ALU_FUNC                - shared operands and function code, held from the last accepted command
//   *_Enable                      - one-hot unit enables, high only in the issue cycle
//   *_OUT, *_Flag                 - registered results and valid flags from the units
//   RSP_VALID/READY/ID/DATA/ERR   - response channel back to the winning requester
//
// Build option: define ALU_SCHED_FIXED_PRIO_EN for fixed priority (port 0 wins contention);
// default build is round-robin.
module alu_op_scheduler #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ0_VALID,
  output logic                      REQ0_READY,
  input  logic [IN_DATA_WIDTH-1:0]  REQ0_A,
  input  logic [IN_DATA_WIDTH-1:0]  REQ0_B,
  input  logic [3:0]                REQ0_OP,
  input  logic                      REQ1_VALID,
  output logic                      REQ1_READY,
  input  logic [IN_DATA_WIDTH-1:0]  REQ1_A,
  input  logic [IN_DATA_WIDTH-1:0]  REQ1_B,
  input  logic [3:0]                REQ1_OP,
  output logic [IN_DATA_WIDTH-1:0]  A,
  output logic [IN_DATA_WIDTH-1:0]  B,
  output logic [1:0]                ALU_FUNC,
  output logic                      Arith_Enable,
  output logic                      Logic_Enable,
  output logic                      CMP_Enable,
  output logic                      SHIFT_Enable,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic                      Arith_Flag,
  input  logic                      Logic_Flag,
  input  logic                      CMP_Flag,
  input  logic                      SHIFT_Flag,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic                      RSP_ID,
  output logic [OUT_DATA_WIDTH-1:0] RSP_DATA,
  output logic                      RSP_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                    state_q;
  logic [IN_DATA_WIDTH-1:0]  a_q, b_q;
  logic [1:0]                func_q;
  logic [1:0]                unit_q;
  logic                      id_q;
  logic                      rsp_vld_q;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_q;
  logic                      rsp_err_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic                      last_grant_q;
`endif

  logic                      grant0, grant1;
  logic                      issue;
  logic [OUT_DATA_WIDTH-1:0] sel_out;
  logic                      sel_flag;

  // Grant is combinational so READY rises in the same cycle as VALID.
  // Gated by RST so nothing is accepted on a reset edge.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !RST) begin
      if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        // The port that did not win last time gets this one.
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
`endif
      end else begin
        grant0 = REQ0_VALID;
        grant1 = REQ1_VALID;
      end
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;

  // Enables are a decode of the latched unit select, live only in ISSUE.
  assign issue        = (state_q == S_ISSUE) && !RST;
  assign Arith_Enable = issue && (unit_q == 2'b00);
  assign Logic_Enable = issue && (unit_q == 2'b01);
  assign CMP_Enable   = issue && (unit_q == 2'b10);
  assign SHIFT_Enable = issue && (unit_q == 2'b11);

  always_comb begin
    sel_out  = Arith_OUT;
    sel_flag = Arith_Flag;
    case (unit_q)
      2'b00:   begin sel_out = Arith_OUT; sel_flag = Arith_Flag; end
      2'b01:   begin sel_out = Logic_OUT; sel_flag = Logic_Flag; end
      2'b10:   begin sel_out = CMP_OUT;   sel_flag = CMP_Flag;   end
      default: begin sel_out = SHIFT_OUT; sel_flag = SHIFT_Flag; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= '0;
      unit_q       <= '0;
      id_q         <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 || grant1) begin
            a_q     <= grant1 ? REQ1_A : REQ0_A;
            b_q     <= grant1 ? REQ1_B : REQ0_B;
            func_q  <= grant1 ? REQ1_OP[1:0] : REQ0_OP[1:0];
            unit_q  <= grant1 ? REQ1_OP[3:2] : REQ0_OP[3:2];
            id_q    <= grant1;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_grant_q <= grant1;
`endif
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          // Unit registered its result at the end of ISSUE; take it now.
          rsp_data_q <= sel_flag ? sel_out : '0;
          rsp_err_q  <= ~sel_flag;
          rsp_vld_q  <= 1'b1;
          state_q    <= S_RESP;
        end
        default: begin
          if (RSP_READY) begin
            rsp_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_FUNC  = func_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_ID    = id_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Testbench for alu_op_scheduler: models the four ALU units, drives table vectors,
// hand-written corner sequences and a randomized run against a transaction-level model.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld [2];
  logic [15:0] pa  [2];
  logic [15:0] pb  [2];
  logic [3:0]  pop [2];
  logic        rsp_rdy = 1'b0;

  logic        rdy0, rdy1;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUNC;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic        arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic        RSP_VALID, RSP_ID, RSP_ERR;
  logic [15:0] RSP_DATA;

  logic [1:0]  rdy;
  logic [3:0]  en;
  assign rdy = {rdy1, rdy0};
  assign en  = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  int   checks = 0;
  int   errors = 0;
  logic flag_cfg [4];
  logic rand_mode = 1'b0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16)) dut (
    .CLK(clk), .RST(rst),
    .REQ0_VALID(vld[0]), .REQ0_READY(rdy0), .REQ0_A(pa[0]), .REQ0_B(pb[0]), .REQ0_OP(pop[0]),
    .REQ1_VALID(vld[1]), .REQ1_READY(rdy1), .REQ1_A(pa[1]), .REQ1_B(pb[1]), .REQ1_OP(pop[1]),
    .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(arith_out), .Logic_OUT(logic_out), .CMP_OUT(cmp_out), .SHIFT_OUT(shift_out),
    .Arith_Flag(arith_flag), .Logic_Flag(logic_flag), .CMP_Flag(cmp_flag), .SHIFT_Flag(shift_flag),
    .RSP_VALID(RSP_VALID), .RSP_READY(rsp_rdy), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  // Behaviour of each execution unit; each gives a distinct result so wrong routing shows up.
  function automatic logic [15:0] unit_result(input logic [1:0] u, input logic [1:0] f,
                                              input logic [15:0] a, input logic [15:0] b);
    case (u)
      2'd0:    return a + b + 16'(f);
      2'd1:    return a ^ b ^ 16'(f);
      2'd2:    return (a > b) ? 16'(f) : 16'h0;
      default: return a << f;
    endcase
  endfunction

  function automatic logic unit_flag(input logic [1:0] u, input logic [15:0] a);
    return rand_mode ? (a[1:0] != 2'b00) : flag_cfg[u];
  endfunction

  always @(posedge clk) begin
    if (Arith_Enable) begin arith_out <= unit_result(2'd0, ALU_FUNC, A, B); arith_flag <= unit_flag(2'd0, A); end
    if (Logic_Enable) begin logic_out <= unit_result(2'd1, ALU_FUNC, A, B); logic_flag <= unit_flag(2'd1, A); end
    if (CMP_Enable)   begin cmp_out   <= unit_result(2'd2, ALU_FUNC, A, B); cmp_flag   <= unit_flag(2'd2, A); end
    if (SHIFT_Enable) begin shift_out <= unit_result(2'd3, ALU_FUNC, A, B); shift_flag <= unit_flag(2'd3, A); end
  end

  // Arbitration rule as a lookup: returns the one-hot READY pattern expected in IDLE.
  function automatic logic [1:0] grant_of(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      return 2'b01;
`else
      return last ? 2'b01 : 2'b10;
`endif
    end
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset with both ports requesting; everything must read zero. Ends in IDLE at posedge+1.
  task automatic apply_reset();
    rst = 1'b1; vld[0] = 1'b1; vld[1] = 1'b1; rsp_rdy = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_ready", rdy, 2'b00);
    chk("rst_enable", en, 4'b0);
    chk("rst_A", A, 16'h0);
    chk("rst_B", B, 16'h0);
    chk("rst_func", ALU_FUNC, 2'b0);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_id", RSP_ID, 1'b0);
    chk("rst_rsp_data", RSP_DATA, 16'h0);
    chk("rst_rsp_err", RSP_ERR, 1'b0);
    step();
    rst = 1'b0; vld[0] = 1'b0; vld[1] = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic        flag;
    logic        exp_id;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  // Single-port command with cycle-by-cycle checks. Starts and ends at posedge+1 in IDLE.
  task automatic do_txn(input vec_t v);
    logic [3:0] exp_en;
    exp_en = 4'b0001 << v.op[3:2];
    flag_cfg[v.op[3:2]] = v.flag;
    pa[v.port] = v.a; pb[v.port] = v.b; pop[v.port] = v.op; vld[v.port] = 1'b1;
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("txn_ready", rdy, v.port ? 2'b10 : 2'b01);
    step();
    vld[v.port] = 1'b0;
    @(negedge clk);
    chk("txn_issue_enable", en, exp_en);
    chk("txn_issue_A", A, v.a);
    chk("txn_issue_B", B, v.b);
    chk("txn_issue_func", ALU_FUNC, v.op[1:0]);
    step();
    @(negedge clk);
    chk("txn_wait_enable", en, 4'b0);
    chk("txn_wait_rsp_valid", RSP_VALID, 1'b0);
    step();
    @(negedge clk);
    chk("txn_rsp_valid", RSP_VALID, 1'b1);
    chk("txn_rsp_id", RSP_ID, v.exp_id);
    chk("txn_rsp_data", RSP_DATA, v.exp_data);
    chk("txn_rsp_err", RSP_ERR, v.exp_err);
    chk("txn_rsp_A_held", A, v.a);
    step();
    @(negedge clk);
    chk("txn_idle_rsp_valid", RSP_VALID, 1'b0);
    step();
  endtask

  vec_t vecs [8];

  initial begin
    logic        exp_seq [4];
    logic        busy, last, w, f, exp_rv, exp_id, exp_err;
    logic [1:0]  exp_rdy, acc;
    logic [3:0]  exp_en, cur_op;
    logic [15:0] exp_data, hold_data;
    int          acc_cyc, nr, ng, nresp;

    for (int i = 0; i < 2; i++) begin vld[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0; end
    for (int i = 0; i < 4; i++) flag_cfg[i] = 1'b1;

    //           port  a         b         op       flag  id    data      err
    vecs[0] = '{1'b0, 16'd5,    16'd3,    4'b1010, 1'b1, 1'b0, 16'd2,    1'b0};
    vecs[1] = '{1'b1, 16'd7,    16'd9,    4'b0000, 1'b1, 1'b1, 16'd16,   1'b0};
    vecs[2] = '{1'b1, 16'h1234, 16'h00FF, 4'b0001, 1'b0, 1'b1, 16'h0,    1'b1};
    vecs[3] = '{1'b0, 16'h00F0, 16'h0F0F, 4'b0110, 1'b1, 1'b0, 16'h0FFD, 1'b0};
    vecs[4] = '{1'b0, 16'd3,    16'd0,    4'b1111, 1'b1, 1'b0, 16'h0018, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'd1,    4'b0011, 1'b1, 1'b1, 16'h0003, 1'b0};
    vecs[6] = '{1'b0, 16'd3,    16'd5,    4'b1001, 1'b1, 1'b0, 16'h0,    1'b0};
    vecs[7] = '{1'b1, 16'h8001, 16'd0,    4'b1101, 1'b0, 1'b1, 16'h0,    1'b1};

    #1;
    apply_reset();
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Both ports valid continuously from reset.
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) flag_cfg[i] = 1'b1;
    pa[0] = 16'd1; pb[0] = 16'd2; pop[0] = 4'b0000;
    pa[1] = 16'd3; pb[1] = 16'd4; pop[1] = 4'b0100;
    vld[0] = 1'b1; vld[1] = 1'b1; rsp_rdy = 1'b1;
    nr = 0; ng = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      if (rdy != 2'b00) begin
        chk("both_single_ready", (rdy == 2'b01) || (rdy == 2'b10), 1'b1);
        if (ng < 4) chk("both_grant_order", rdy[1], exp_seq[ng]);
        ng++;
      end
      if (RSP_VALID) begin
        chk("both_rsp_id", RSP_ID, exp_seq[nr]);
        chk("both_rsp_data", RSP_DATA, exp_seq[nr] ? 16'd7 : 16'd3);
        nr++;
      end
      step();
      if (nr == 4) begin vld[0] = 1'b0; vld[1] = 1'b0; end
    end
    chk("both_rsp_count", nr, 4);
    vld[0] = 1'b0; vld[1] = 1'b0;
    step(); step(); step(); step();

    // Response backpressure with port 1 waiting.
    apply_reset();
    flag_cfg[0] = 1'b1; flag_cfg[1] = 1'b1;
    pa[0] = 16'd9; pb[0] = 16'd4; pop[0] = 4'b0000; vld[0] = 1'b1; rsp_rdy = 1'b0;
    step();
    vld[0] = 1'b0;
    pa[1] = 16'd1; pb[1] = 16'd3; pop[1] = 4'b0100; vld[1] = 1'b1;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", RSP_VALID, 1'b1);
      chk("bp_rsp_data", RSP_DATA, 16'd13);
      chk("bp_rsp_id", RSP_ID, 1'b0);
      chk("bp_ready", rdy, 2'b00);
      step();
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", RSP_VALID, 1'b1);
    chk("bp_release_ready", rdy, 2'b00);
    step();
    @(negedge clk);
    chk("bp_after_valid", RSP_VALID, 1'b0);
    chk("bp_after_ready", rdy, 2'b10);
    step();
    vld[1] = 1'b0;
    step(); step();
    @(negedge clk);
    chk("bp_p1_valid", RSP_VALID, 1'b1);
    chk("bp_p1_id", RSP_ID, 1'b1);
    chk("bp_p1_data", RSP_DATA, 16'd2);
    step(); step();

    // Reset pulsed while the command is in WAIT; port 0 keeps requesting.
    flag_cfg[2] = 1'b1;
    pa[0] = 16'd5; pb[0] = 16'd3; pop[0] = 4'b1010; vld[0] = 1'b1; rsp_rdy = 1'b1;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rw_enable", en, 4'b0);
    chk("rw_ready", rdy, 2'b00);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_A", A, 16'h0);
    chk("rw_func", ALU_FUNC, 2'b0);
    chk("rw_rsp_valid", RSP_VALID, 1'b0);
    chk("rw_rsp_data", RSP_DATA, 16'h0);
    chk("rw_reaccept", rdy, 2'b01);
    step();
    vld[0] = 1'b0;
    @(negedge clk);
    chk("rw_enable2", en, 4'b0100);
    step(); step();
    @(negedge clk);
    chk("rw_rsp_valid2", RSP_VALID, 1'b1);
    chk("rw_rsp_data2", RSP_DATA, 16'd2);
    step(); step();

    // Randomized traffic against a transaction-level model.
    apply_reset();
    rand_mode = 1'b1;
    busy = 1'b0; last = 1'b1; acc = 2'b00; acc_cyc = 0; nresp = 0;
    cur_op = '0; exp_id = 1'b0; exp_data = '0; exp_err = 1'b0; hold_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) vld[p] = 1'b0;
        if (!vld[p]) begin
          if ($urandom_range(2) == 0) begin
            pa[p] = 16'($urandom); pb[p] = 16'($urandom); pop[p] = 4'($urandom); vld[p] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          vld[p] = 1'b0;
        end
      end
      rsp_rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      exp_rdy = busy ? 2'b00 : grant_of(vld[0], vld[1], last);
      exp_rv  = busy && (cyc >= acc_cyc + 3);
      exp_en  = (busy && cyc == acc_cyc + 1) ? (4'b0001 << cur_op[3:2]) : 4'b0;
      chk("rnd_ready", rdy, exp_rdy);
      chk("rnd_rsp_valid", RSP_VALID, exp_rv);
      chk("rnd_enable", en, exp_en);
      if (exp_rv && RSP_VALID) begin
        chk("rnd_rsp_id", RSP_ID, exp_id);
        chk("rnd_rsp_data", RSP_DATA, exp_data);
        chk("rnd_rsp_err", RSP_ERR, exp_err);
      end
      acc = 2'b00;
      if (exp_rv && rsp_rdy) begin
        busy = 1'b0;
        nresp++;
      end else if (!busy && exp_rdy != 2'b00) begin
        w        = exp_rdy[1];
        busy     = 1'b1;
        acc_cyc  = cyc;
        last     = w;
        acc      = exp_rdy;
        cur_op   = pop[w];
        exp_id   = w;
        f        = (pa[w][1:0] != 2'b00);
        hold_data = unit_result(pop[w][3:2], pop[w][1:0], pa[w], pb[w]);
        exp_err  = ~f;
        exp_data = f ? hold_data : 16'h0;
      end
      step();
    end
    chk("rnd_progress", nresp > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
